// File: rtl/control_unit.sv
// control_unit: multi-cycle Moore controller for the accumulator computer.
// It sequences PC, IR, memory, accumulator/ALU and the switch/LED ports through
// FETCH -> DECODE -> (operation) -> FETCH. It also keeps a saturating count of
// retired instructions.
// Optional build macro CONTROL_UNIT_ILLEGAL_TRAP_EN: when defined, an illegal
// opcode traps into HALT and raises illegal_op. When undefined, an illegal
// opcode acts as an uncounted NOP and illegal_op is tied low.
module control_unit #(
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [3:0]             opcode,
    input  logic                   acc_zero,
    input  logic                   mem_ready,
    output logic                   pc_inc,
    output logic                   pc_load,
    output logic                   ir_load,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic                   acc_load,
    output logic [1:0]             acc_src,
    output logic [1:0]             alu_op,
    output logic                   led_load,
    output logic                   halted,
    output logic                   illegal_op,
    output logic [COUNT_WIDTH-1:0] instr_count
);

    // Instruction opcodes (IR[7:4])
    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_AND   = 4'h5;
    localparam logic [3:0] OP_JUMP  = 4'h6;
    localparam logic [3:0] OP_JZ    = 4'h7;
    localparam logic [3:0] OP_IN    = 4'h8;
    localparam logic [3:0] OP_OUT   = 4'h9;
    localparam logic [3:0] OP_HALT  = 4'hF;

    // FSM states
    localparam logic [3:0] FETCH  = 4'd0;
    localparam logic [3:0] DECODE = 4'd1;
    localparam logic [3:0] MEM_RD = 4'd2;
    localparam logic [3:0] EXEC   = 4'd3;
    localparam logic [3:0] MEM_WR = 4'd4;
    localparam logic [3:0] JUMP   = 4'd5;
    localparam logic [3:0] IO_IN  = 4'd6;
    localparam logic [3:0] IO_OUT = 4'd7;
    localparam logic [3:0] HALT   = 4'd8;

    // Accumulator source and ALU operation encodings
    localparam logic [1:0] SRC_MEM  = 2'b00;
    localparam logic [1:0] SRC_ALU  = 2'b01;
    localparam logic [1:0] SRC_SW   = 2'b10;
    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_AND  = 2'b10;

    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);

    logic [3:0]             state_q;
    logic [3:0]             state_d;
    logic [3:0]             op_q;
    logic [COUNT_WIDTH-1:0] count_q;
    logic                   opcode_counted;
    logic                   count_en;

    // NOP..OUT retire and are counted; HALT and A-E are not.
    assign opcode_counted = (opcode <= OP_OUT);
    assign count_en       = (state_q == DECODE) && opcode_counted && (count_q != '1);

    // Next-state selection; opcode is only consulted in DECODE
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH: begin
                if (mem_ready) begin
                    state_d = DECODE;
                end
            end
            DECODE: begin
                case (opcode)
                    OP_NOP:                          state_d = FETCH;
                    OP_LOAD, OP_ADD, OP_SUB, OP_AND: state_d = MEM_RD;
                    OP_STORE:                        state_d = MEM_WR;
                    OP_JUMP:                         state_d = JUMP;
                    OP_JZ:                           state_d = acc_zero ? JUMP : FETCH;
                    OP_IN:                           state_d = IO_IN;
                    OP_OUT:                          state_d = IO_OUT;
                    OP_HALT:                         state_d = HALT;
`ifdef CONTROL_UNIT_ILLEGAL_TRAP_EN
                    default:                         state_d = HALT;
`else
                    default:                         state_d = FETCH;
`endif
                endcase
            end
            MEM_RD: begin
                if (mem_ready) begin
                    state_d = EXEC;
                end
            end
            MEM_WR: begin
                if (mem_ready) begin
                    state_d = FETCH;
                end
            end
            EXEC, JUMP, IO_IN, IO_OUT: state_d = FETCH;
            HALT:                      state_d = HALT;
            default:                   state_d = FETCH;
        endcase
    end

    // State register with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the opcode in DECODE so EXEC is immune to later IR/opcode changes
    always_ff @(posedge clock) begin
        if (reset) begin
            op_q <= OP_NOP;
        end else if (state_q == DECODE) begin
            op_q <= opcode;
        end
    end

    // Retired-instruction counter, saturating at all-ones
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else if (count_en) begin
            count_q <= count_q + COUNT_ONE;
        end
    end

    assign instr_count = count_q;

`ifdef CONTROL_UNIT_ILLEGAL_TRAP_EN
    logic opcode_legal;
    logic illegal_q;

    assign opcode_legal = opcode_counted || (opcode == OP_HALT);

    // Sticky illegal-opcode flag, set on the edge that traps into HALT
    always_ff @(posedge clock) begin
        if (reset) begin
            illegal_q <= 1'b0;
        end else if ((state_q == DECODE) && !opcode_legal) begin
            illegal_q <= 1'b1;
        end
    end

    assign illegal_op = illegal_q;
`else
    assign illegal_op = 1'b0;
`endif

    // Strobe decode from the state register; only FETCH's ir_load/pc_inc see mem_ready.
    // Strobes are forced low while reset is asserted.
    always_comb begin
        pc_inc    = 1'b0;
        pc_load   = 1'b0;
        ir_load   = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        acc_load  = 1'b0;
        acc_src   = SRC_MEM;
        alu_op    = ALU_ADD;
        led_load  = 1'b0;
        halted    = (state_q == HALT);
        if (!reset) begin
            case (state_q)
                FETCH: begin
                    mem_read = 1'b1;
                    ir_load  = mem_ready;
                    pc_inc   = mem_ready;
                end
                MEM_RD: mem_read = 1'b1;
                EXEC: begin
                    acc_load = 1'b1;
                    case (op_q)
                        OP_ADD: begin
                            acc_src = SRC_ALU;
                            alu_op  = ALU_ADD;
                        end
                        OP_SUB: begin
                            acc_src = SRC_ALU;
                            alu_op  = ALU_SUB;
                        end
                        OP_AND: begin
                            acc_src = SRC_ALU;
                            alu_op  = ALU_AND;
                        end
                        default: acc_src = SRC_MEM;
                    endcase
                end
                MEM_WR: mem_write = 1'b1;
                JUMP:   pc_load   = 1'b1;
                IO_IN: begin
                    acc_load = 1'b1;
                    acc_src  = SRC_SW;
                end
                IO_OUT:  led_load = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
Multi-cycle control unit (Moore FSM) for the accumulator computer in `system`; sequences PC, IR, memory, ALU/accumulator and the switch/LED I/O ports.
- Drives one-hot-style strobes each cycle from the registered state; the datapath does the work.
- Waits on a memory-ready handshake.
- Counts retired instructions.

Parameters:
- COUNT_WIDTH, 16, width of the retired-instruction counter.

Ports:
- clock  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; sampled on rising edge of clock
- opcode  input  4  IR[7:4], valid from DECODE onward
- acc_zero  input  1  accumulator == 0 flag from datapath
- mem_ready  input  1  memory completes the current read/write this cycle
- pc_inc  output  1  increment PC
- pc_load  output  1  load PC from IR operand
- ir_load  output  1  load IR from memory read data
- mem_read  output  1  memory read strobe
- mem_write  output  1  memory write strobe (data = accumulator)
- acc_load  output  1  load accumulator
- acc_src  output  2  accumulator source: 00 memory, 01 ALU, 10 switches
- alu_op  output  2  00 ADD, 01 SUB, 10 AND, 11 unused
- led_load  output  1  load LED register from accumulator[3:0]
- halted  output  1  FSM in HALT
- illegal_op  output  1  see Optional Feature
- instr_count  output  COUNT_WIDTH  retired-instruction count

Behaviour:
- Opcodes: 0 NOP, 1 LOAD, 2 STORE, 3 ADD, 4 SUB, 5 AND, 6 JUMP, 7 JZ, 8 IN, 9 OUT, F HALT; A-E illegal.
- Outputs are decoded from the state register only (Moore). No input combinationally affects any output.
- Reset:
  - state = FETCH, instr_count = 0, illegal_op = 0.
  - All strobes are 0 during the reset cycle.
  - Reset mid-instruction (including while stalled on mem_ready, or in HALT) aborts on the next edge.
- FETCH: mem_read=1. When mem_ready=1, also assert ir_load=1 and pc_inc=1, then go to DECODE. If mem_ready=0, hold FETCH with ir_load=0 and pc_inc=0.
  - ir_load and pc_inc are the only strobes gated by mem_ready. This is a permitted exception to Moore output, for FETCH only.
- DECODE: all strobes 0. Next state:
  - NOP→FETCH
  - LOAD/ADD/SUB/AND→MEM_RD
  - STORE→MEM_WR
  - JUMP→JUMP
  - JZ→JUMP if acc_zero=1, else FETCH
  - IN→IO_IN
  - OUT→IO_OUT
  - HALT→HALT
  - illegal→FETCH
- MEM_RD: mem_read=1; go to EXEC when mem_ready=1, else hold.
- EXEC: acc_load=1; then FETCH.
  - LOAD: acc_src=00.
  - ADD/SUB/AND: acc_src=01 with alu_op=00/01/10.
- MEM_WR: mem_write=1; go to FETCH when mem_ready=1, else hold (mem_write stays 1).
- JUMP: pc_load=1; then FETCH.
- IO_IN: acc_load=1, acc_src=10; then FETCH.
- IO_OUT: led_load=1; then FETCH.
- HALT: halted=1, all strobes 0; remains until reset.
- Cycle counts with mem_ready tied 1:
  - NOP 2, LOAD/ADD/SUB/AND 4, STORE 3, JUMP 3, JZ taken 3 / not taken 2, IN 3, OUT 3.
  - Each cycle with mem_ready=0 in FETCH/MEM_RD/MEM_WR adds one.
- Defaults: acc_src and alu_op are 00 in every state not listed above.
- instr_count:
  - Increments by 1 on the edge leaving DECODE, for every opcode except HALT and illegal.
  - Saturates at all-ones; no wrap.
- A new opcode value is only sampled in DECODE; opcode changes in other states are ignored.

Optional Feature:
CONTROL_UNIT_ILLEGAL_TRAP_EN
- Defined: an illegal opcode in DECODE goes to HALT, and illegal_op is set to 1 on that edge. illegal_op stays 1 until reset; halted=1.
- Undefined: illegal opcodes behave as NOP but are not counted, and illegal_op is tied to 0.

Test Plan:
- Reset held 2 cycles then released, mem_ready=1, opcode=0 → all strobes 0 during reset; first cycle after release FETCH (mem_read=1, ir_load=1, pc_inc=1); FETCH/DECODE alternate; instr_count=3 after 6 cycles.
- Program IN(8), OUT(9), JUMP(6) loop, mem_ready=1 → per loop: acc_load with acc_src=10 at cycle 3, led_load at cycle 6, pc_load at cycle 9; loop length 9 cycles; instr_count +3 per loop.
- ADD(3) with mem_ready low for 2 cycles in MEM_RD → mem_read high 3 cycles; acc_load=1 with acc_src=01 and alu_op=00 exactly one cycle later; total 6 cycles.
- JZ(7) with acc_zero=1 → pc_load asserted in cycle 3. JZ with acc_zero=0 → no pc_load, next FETCH at cycle 3.
- HALT(F) → halted=1 from cycle 3 onward, strobes 0, instr_count unchanged for 20 cycles; reset during HALT → FETCH next cycle, halted=0.
- Opcode B (illegal) → with CONTROL_UNIT_ILLEGAL_TRAP_EN: halted=1 and illegal_op=1. Without it: 2-cycle NOP, instr_count unchanged, illegal_op=0.
